// File: rtl/spike_sprite_fetch.sv
// -----------------------------------------------------------------------------
// spike_sprite_fetch
//
// Pixel-rate sprite fetch pipeline. For every raster pixel it decides whether
// the pixel lies inside the sprite box. If it does, it issues a word read to a
// synchronous sprite BRAM holding N_FRAMES frames back-to-back. Each BRAM word
// packs 8 pixels as 4-bit palette indices (nibble k = pixel k of the word).
// The raster/sprite coordinates are delayed so that they line up with the
// returned word.
//
// Timing: inputs sampled at edge n are registered at the outputs at edge n+2.
//   edge n   : rom_addr / rom_rden issued (stage 1)
//   edge n+1 : BRAM registers rom_dout
//   edge n+2 : Spike_data / SpikeHit / *_o updated
//
// Optional build macro:
//   SPIKE_FETCH_RDEN_GATE_EN - suppress repeated reads of the word already
//                              fetched. Outputs are identical to the ungated
//                              build, cycle for cycle.
//
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   DrawX, DrawY          current raster pixel
//   SpikeX, SpikeY        sprite top-left corner
//   vde                   active-video qualifier
//   sprite_sel            frame index (out-of-range selects frame 0)
//   rom_addr, rom_rden    registered BRAM word address / read enable
//   rom_dout              BRAM read data, valid one cycle after rom_rden
//   DrawX_o .. SpikeY_o   inputs delayed to align with Spike_data
//   Spike_data            fetched word, zero when the aligned pixel misses
//   SpikeHit              aligned pixel is inside the sprite box with vde high
// -----------------------------------------------------------------------------
module spike_sprite_fetch #(
   parameter int unsigned SPR_W    = 20,
   parameter int unsigned SPR_H    = 20,
   parameter int unsigned N_FRAMES = 4
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic [9:0]  SpikeX,
   input  logic [9:0]  SpikeY,
   input  logic        vde,
   input  logic [1:0]  sprite_sel,
   output logic [7:0]  rom_addr,
   output logic        rom_rden,
   input  logic [31:0] rom_dout,
   output logic [9:0]  DrawX_o,
   output logic [9:0]  DrawY_o,
   output logic [9:0]  SpikeX_o,
   output logic [9:0]  SpikeY_o,
   output logic [31:0] Spike_data,
   output logic        SpikeHit
);

   localparam int unsigned WORDS_PER_FRAME = (SPR_W * SPR_H) / 8;

   // ---------------------------------------------------------------- stage 0
   logic [10:0] x_end, y_end;
   logic [9:0]  rel_x, rel_y;
   logic [19:0] pix;
   logic [1:0]  sel_eff;
   logic [7:0]  word;
   logic        hit;

   always_comb begin
      // Box ends are formed with 11 bits so a sprite near 1023 does not wrap
      // around and claim pixels at the left/top of the screen.
      x_end   = {1'b0, SpikeX} + 11'(SPR_W);
      y_end   = {1'b0, SpikeY} + 11'(SPR_H);
      hit     = vde
                && (DrawX >= SpikeX) && ({1'b0, DrawX} < x_end)
                && (DrawY >= SpikeY) && ({1'b0, DrawY} < y_end);
      rel_x   = DrawX - SpikeX;
      rel_y   = DrawY - SpikeY;
      pix     = 20'(rel_x) + 20'(rel_y) * 20'(SPR_W);
      sel_eff = ({30'd0, sprite_sel} >= N_FRAMES) ? 2'd0 : sprite_sel;
      word    = 8'(20'(sel_eff) * 20'(WORDS_PER_FRAME) + (pix >> 3));
   end

   // ---------------------------------------------------------- pipeline regs
   logic [7:0]  rom_addr_q, rom_addr_d;
   logic        rom_rden_q, rom_rden_d;
   logic        hit1_q, hit2_q, hit3_q;
   logic        rden2_q;
   logic [9:0]  dx1_q, dy1_q, sx1_q, sy1_q;
   logic [9:0]  dx2_q, dy2_q, sx2_q, sy2_q;
   logic [9:0]  dx3_q, dy3_q, sx3_q, sy3_q;
   logic [31:0] data_q, data_d;

`ifdef SPIKE_FETCH_RDEN_GATE_EN
   logic        cache_vld_q, cache_vld_d;
   logic [1:0]  cache_sel_q, cache_sel_d;
`endif

   always_comb begin
      rom_addr_d = hit ? word : rom_addr_q;
`ifdef SPIKE_FETCH_RDEN_GATE_EN
      // rom_addr_q always holds the last issued word, so it doubles as the
      // cache tag. Any miss cycle drops the cache, which guarantees the first
      // hit after a gap always re-reads.
      cache_vld_d = hit;
      cache_sel_d = hit ? sel_eff : cache_sel_q;
      rom_rden_d  = hit && (!cache_vld_q || (word != rom_addr_q)
                            || (sel_eff != cache_sel_q));
`else
      rom_rden_d  = hit;
`endif
      // Without a new read, the BRAM word is the one already captured.
      if (!hit2_q) begin
         data_d = '0;
      end else if (rden2_q) begin
         data_d = rom_dout;
      end else begin
         data_d = data_q;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rom_addr_q  <= '0;
         rom_rden_q  <= 1'b0;
         hit1_q      <= 1'b0;
         hit2_q      <= 1'b0;
         hit3_q      <= 1'b0;
         rden2_q     <= 1'b0;
         dx1_q       <= '0;
         dy1_q       <= '0;
         sx1_q       <= '0;
         sy1_q       <= '0;
         dx2_q       <= '0;
         dy2_q       <= '0;
         sx2_q       <= '0;
         sy2_q       <= '0;
         dx3_q       <= '0;
         dy3_q       <= '0;
         sx3_q       <= '0;
         sy3_q       <= '0;
         data_q      <= '0;
`ifdef SPIKE_FETCH_RDEN_GATE_EN
         cache_vld_q <= 1'b0;
         cache_sel_q <= '0;
`endif
      end else begin
         rom_addr_q  <= rom_addr_d;
         rom_rden_q  <= rom_rden_d;
         hit1_q      <= hit;
         hit2_q      <= hit1_q;
         hit3_q      <= hit2_q;
         rden2_q     <= rom_rden_q;
         dx1_q       <= DrawX;
         dy1_q       <= DrawY;
         sx1_q       <= SpikeX;
         sy1_q       <= SpikeY;
         dx2_q       <= dx1_q;
         dy2_q       <= dy1_q;
         sx2_q       <= sx1_q;
         sy2_q       <= sy1_q;
         dx3_q       <= dx2_q;
         dy3_q       <= dy2_q;
         sx3_q       <= sx2_q;
         sy3_q       <= sy2_q;
         data_q      <= data_d;
`ifdef SPIKE_FETCH_RDEN_GATE_EN
         cache_vld_q <= cache_vld_d;
         cache_sel_q <= cache_sel_d;
`endif
      end
   end

   assign rom_addr   = rom_addr_q;
   assign rom_rden   = rom_rden_q;
   assign DrawX_o    = dx3_q;
   assign DrawY_o    = dy3_q;
   assign SpikeX_o   = sx3_q;
   assign SpikeY_o   = sy3_q;
   assign Spike_data = data_q;
   assign SpikeHit   = hit3_q;

endmodule

// File: tb/tb_spike_sprite_fetch.sv
// -----------------------------------------------------------------------------
// Testbench for spike_sprite_fetch. Drives raster rows one pixel per clock,
// models the synchronous sprite BRAM, and compares aligned outputs against
// values derived from the sprite geometry. N_FRAMES is set to 3 so that an
// out-of-range sprite_sel (3) can be exercised.
// -----------------------------------------------------------------------------
module tb_spike_sprite_fetch;

   localparam int SPR_W = 20;
   localparam int SPR_H = 20;
   localparam int NF    = 3;
   localparam int WPF   = 50;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b1;
   logic [9:0]  DrawX = '0, DrawY = '0, SpikeX = '0, SpikeY = '0;
   logic        vde = 1'b0;
   logic [1:0]  sprite_sel = '0;
   logic [7:0]  rom_addr;
   logic        rom_rden;
   logic [31:0] rom_dout = '0;
   logic [9:0]  DrawX_o, DrawY_o, SpikeX_o, SpikeY_o;
   logic [31:0] Spike_data;
   logic        SpikeHit;

   always #5 Clk = ~Clk;

   spike_sprite_fetch #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .N_FRAMES(NF)
   ) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .DrawX     (DrawX),
      .DrawY     (DrawY),
      .SpikeX    (SpikeX),
      .SpikeY    (SpikeY),
      .vde       (vde),
      .sprite_sel(sprite_sel),
      .rom_addr  (rom_addr),
      .rom_rden  (rom_rden),
      .rom_dout  (rom_dout),
      .DrawX_o   (DrawX_o),
      .DrawY_o   (DrawY_o),
      .SpikeX_o  (SpikeX_o),
      .SpikeY_o  (SpikeY_o),
      .Spike_data(Spike_data),
      .SpikeHit  (SpikeHit)
   );

   function automatic logic [31:0] bram_word(input logic [7:0] a);
      logic [7:0] b;
      b = a + 8'h3C;
      return {a, ~a, a ^ 8'hA5, b};
   endfunction

   // Synchronous-read BRAM: data appears the cycle after rom_rden.
   always @(posedge Clk) begin
      if (rom_rden) rom_dout <= bram_word(rom_addr);
   end

   int tests = 0;
   int fails = 0;
   int sx_g, sy_g;
   int in_x[64], in_y[64], in_sel[64];
   bit in_v[64];
   logic        obs_hit[64];
   logic [31:0] obs_data[64];
   logic [9:0]  obs_dx[64];
   int nstep;
   int rden_cnt;
   int addr_log[$];

   function automatic bit exp_hit(input int k);
      return in_v[k] && (in_x[k] >= sx_g) && (in_x[k] < sx_g + SPR_W)
             && (in_y[k] >= sy_g) && (in_y[k] < sy_g + SPR_H);
   endfunction

   function automatic logic [31:0] exp_data(input int k);
      int s, p;
      if (!exp_hit(k)) return 32'h0;
      s = (in_sel[k] >= NF) ? 0 : in_sel[k];
      p = (in_x[k] - sx_g) + (in_y[k] - sy_g) * SPR_W;
      return bram_word(8'(s * WPF + p / 8));
   endfunction

   task automatic begin_row(input int sx, input int sy);
      sx_g = sx;
      sy_g = sy;
      nstep = 0;
      rden_cnt = 0;
      addr_log.delete();
   endtask

   // One pixel: drive at the negedge, let one rising edge pass, observe at
   // the next negedge. Outputs seen then belong to the pixel driven two
   // steps earlier.
   task automatic step(input int x, input int y, input int sel, input bit v);
      DrawX = 10'(x);
      DrawY = 10'(y);
      SpikeX = 10'(sx_g);
      SpikeY = 10'(sy_g);
      sprite_sel = 2'(sel);
      vde = v;
      in_x[nstep] = x;
      in_y[nstep] = y;
      in_sel[nstep] = sel;
      in_v[nstep] = v;
      @(posedge Clk);
      @(negedge Clk);
      if (rom_rden) begin
         rden_cnt++;
         if (addr_log.size() == 0 || addr_log[$] != int'(rom_addr))
            addr_log.push_back(int'(rom_addr));
      end
      if (nstep >= 2) begin
         obs_hit[nstep-2]  = SpikeHit;
         obs_data[nstep-2] = Spike_data;
         obs_dx[nstep-2]   = DrawX_o;
      end
      nstep++;
   endtask

   task automatic run_row(input int x0, input int n, input int y, input int sel, input bit v);
      for (int i = 0; i < n; i++) step((x0 + i) % 1024, y, sel, v);
      step((x0 + n) % 1024, y, sel, 1'b0);
      step((x0 + n + 1) % 1024, y, sel, 1'b0);
   endtask

   task automatic test_reset();
      @(negedge Clk);
      SpikeX = 10'd100; SpikeY = 10'd50; DrawX = 10'd100; DrawY = 10'd50; vde = 1'b1;
      Reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      tests++;
      if ({rom_addr, rom_rden} !== 9'h0) begin
         fails++; $display("FAIL reset_rom: got %0h expected 0", {rom_addr, rom_rden});
      end
      tests++;
      if (Spike_data !== 32'h0) begin
         fails++; $display("FAIL reset_data: got %0h expected 0", Spike_data);
      end
      tests++;
      if (SpikeHit !== 1'b0) begin
         fails++; $display("FAIL reset_hit: got %0b expected 0", SpikeHit);
      end
      tests++;
      if ({DrawX_o, DrawY_o, SpikeX_o, SpikeY_o} !== 40'h0) begin
         fails++; $display("FAIL reset_coords: got %0h expected 0", {DrawX_o, DrawY_o, SpikeX_o, SpikeY_o});
      end
      vde = 1'b0;
      Reset_n = 1'b1;
   endtask

   task automatic test_sweep();
      int hcnt, first;
      int exp_r;
      begin_row(100, 50);
      run_row(95, 31, 50, 0, 1'b1);
      hcnt = 0;
      first = -1;
      for (int k = 0; k < 31; k++) begin
         tests++;
         if (obs_hit[k] !== exp_hit(k)) begin
            fails++; $display("FAIL sweep_hit x=%0d: got %0b expected %0b", in_x[k], obs_hit[k], exp_hit(k));
         end
         tests++;
         if (obs_data[k] !== exp_data(k)) begin
            fails++; $display("FAIL sweep_data x=%0d: got %08h expected %08h", in_x[k], obs_data[k], exp_data(k));
         end
         tests++;
         if (obs_dx[k] !== 10'(in_x[k])) begin
            fails++; $display("FAIL sweep_drawx_o k=%0d: got %0d expected %0d", k, obs_dx[k], in_x[k]);
         end
         if (obs_hit[k] === 1'b1) begin
            hcnt++;
            if (first < 0) first = k;
         end
      end
      tests++;
      if (hcnt != 20) begin
         fails++; $display("FAIL sweep_hit_count: got %0d expected 20", hcnt);
      end
      tests++;
      if (first < 0 || in_x[first] != 100) begin
         fails++; $display("FAIL sweep_first_hit: got index %0d expected DrawX 100", first);
      end
`ifdef SPIKE_FETCH_RDEN_GATE_EN
      exp_r = 3;
`else
      exp_r = 20;
`endif
      tests++;
      if (rden_cnt != exp_r) begin
         fails++; $display("FAIL sweep_rden_count: got %0d expected %0d", rden_cnt, exp_r);
      end
      tests++;
      if (addr_log.size() != 3 || addr_log[0] != 0 || addr_log[1] != 1 || addr_log[2] != 2) begin
         fails++; $display("FAIL sweep_addr_seq: got %0d entries (%p) expected 0,1,2", addr_log.size(), addr_log);
      end
   endtask

   task automatic test_row_sel2();
      begin_row(100, 50);
      run_row(100, 20, 51, 2, 1'b1);
      for (int k = 0; k < 20; k++) begin
         tests++;
         if (obs_data[k] !== exp_data(k) || obs_hit[k] !== 1'b1) begin
            fails++; $display("FAIL sel2_data x=%0d: got %08h/%0b expected %08h/1", in_x[k], obs_data[k], obs_hit[k], exp_data(k));
         end
      end
      tests++;
      if (addr_log.size() != 3 || addr_log[0] != 102 || addr_log[1] != 103 || addr_log[2] != 104) begin
         fails++; $display("FAIL sel2_addr_seq: got %p expected 102,103,104", addr_log);
      end
   endtask

   task automatic test_sel_oob();
      begin_row(100, 50);
      run_row(100, 20, 50, 3, 1'b1);
      for (int k = 0; k < 20; k++) begin
         tests++;
         if (obs_data[k] !== exp_data(k)) begin
            fails++; $display("FAIL sel_oob_data x=%0d: got %08h expected %08h", in_x[k], obs_data[k], exp_data(k));
         end
      end
      tests++;
      if (addr_log.size() != 3 || addr_log[0] != 0 || addr_log[1] != 1 || addr_log[2] != 2) begin
         fails++; $display("FAIL sel_oob_addr_seq: got %p expected 0,1,2", addr_log);
      end
   endtask

   task automatic test_no_wrap();
      begin_row(1015, 50);
      run_row(1020, 6, 50, 0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         tests++;
         if (obs_hit[k] !== exp_hit(k) || obs_data[k] !== exp_data(k)) begin
            fails++; $display("FAIL wrap_pix x=%0d: got %0b/%08h expected %0b/%08h", in_x[k], obs_hit[k], obs_data[k], exp_hit(k), exp_data(k));
         end
      end
      tests++;
      if (obs_hit[3] !== 1'b1 || obs_data[3] !== bram_word(8'd1)) begin
         fails++; $display("FAIL wrap_1023: got %0b/%08h expected 1/%08h", obs_hit[3], obs_data[3], bram_word(8'd1));
      end
      tests++;
      if (obs_hit[4] !== 1'b0 || obs_data[4] !== 32'h0) begin
         fails++; $display("FAIL wrap_x0: got %0b/%08h expected 0/0", obs_hit[4], obs_data[4]);
      end
      tests++;
      if (addr_log.size() != 2 || addr_log[0] != 0 || addr_log[1] != 1) begin
         fails++; $display("FAIL wrap_addr_seq: got %p expected 0,1", addr_log);
      end
   endtask

   task automatic test_sel_switch();
      begin_row(100, 50);
      for (int i = 0; i < 20; i++) step(100 + i, 50, (i < 4) ? 0 : 1, 1'b1);
      step(120, 50, 1, 1'b0);
      step(121, 50, 1, 1'b0);
      for (int k = 0; k < 20; k++) begin
         tests++;
         if (obs_data[k] !== exp_data(k)) begin
            fails++; $display("FAIL switch_data x=%0d: got %08h expected %08h", in_x[k], obs_data[k], exp_data(k));
         end
      end
      tests++;
      if (addr_log.size() != 4 || addr_log[0] != 0 || addr_log[1] != 50 || addr_log[2] != 51 || addr_log[3] != 52) begin
         fails++; $display("FAIL switch_addr_seq: got %p expected 0,50,51,52", addr_log);
      end
   endtask

   task automatic test_vde_low();
      begin_row(100, 50);
      run_row(100, 20, 50, 0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         tests++;
         if (obs_hit[k] !== 1'b0 || obs_data[k] !== 32'h0) begin
            fails++; $display("FAIL vde_low x=%0d: got %0b/%08h expected 0/0", in_x[k], obs_hit[k], obs_data[k]);
         end
      end
      tests++;
      if (rden_cnt != 0) begin
         fails++; $display("FAIL vde_low_rden: got %0d expected 0", rden_cnt);
      end
   endtask

   task automatic test_reset_midbox();
      begin_row(100, 50);
      for (int x = 95; x <= 110; x++) step(x, 50, 0, 1'b1);
      tests++;
      if (SpikeHit !== 1'b1) begin
         fails++; $display("FAIL midbox_pre_hit: got %0b expected 1", SpikeHit);
      end
      #2;
      Reset_n = 1'b0;
      #1;
      tests++;
      if (SpikeHit !== 1'b0 || Spike_data !== 32'h0) begin
         fails++; $display("FAIL midbox_async_out: got %0b/%08h expected 0/0", SpikeHit, Spike_data);
      end
      tests++;
      if ({rom_addr, rom_rden} !== 9'h0 || DrawX_o !== 10'd0) begin
         fails++; $display("FAIL midbox_async_rom: got %0h/%0d expected 0/0", {rom_addr, rom_rden}, DrawX_o);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      nstep = 0;
      step(111, 50, 0, 1'b1);
      tests++;
      if (rom_addr !== 8'd1 || rom_rden !== 1'b1) begin
         fails++; $display("FAIL midbox_resume_rom: got %0d/%0b expected 1/1", rom_addr, rom_rden);
      end
      tests++;
      if (SpikeHit !== 1'b0) begin
         fails++; $display("FAIL midbox_resume_hit0: got %0b expected 0", SpikeHit);
      end
      step(112, 50, 0, 1'b1);
      tests++;
      if (SpikeHit !== 1'b0) begin
         fails++; $display("FAIL midbox_resume_hit1: got %0b expected 0", SpikeHit);
      end
      step(113, 50, 0, 1'b1);
      tests++;
      if (SpikeHit !== 1'b1 || DrawX_o !== 10'd111 || Spike_data !== bram_word(8'd1)) begin
         fails++; $display("FAIL midbox_resume_out: got %0b/%0d/%08h expected 1/111/%08h", SpikeHit, DrawX_o, Spike_data, bram_word(8'd1));
      end
      step(114, 50, 0, 1'b0);
      step(115, 50, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_row_sel2();
      test_sel_oob();
      test_no_wrap();
      test_sel_switch();
      test_vde_low();
      test_reset_midbox();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
